// File: rtl/rom_download_ctrl.sv
// rom_download_ctrl: queues ioctl download bytes and replays them to NPORTS toggle-handshake
// sdram write ports, tracks load completion and stretches the core reset. Option: ROM_CHECKSUM_EN.
module rom_download_ctrl #(
  parameter int         NPORTS     = 2,
  parameter int         ADDR_W     = 23,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ROM_INDEX  = 8'd0,
  parameter int         RST_CNT_W  = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_downl,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [NPORTS-1:0] port_en,
  output logic [NPORTS-1:0] port_req,
  input  logic [NPORTS-1:0] port_ack,
  output logic [ADDR_W-1:0] port_a,
  output logic [1:0]        port_ds,
  output logic [15:0]       port_d,
  output logic              port_we,
  input  logic              reset_req,
  output logic              rom_loaded,
  output logic              busy,
  output logic              overflow,
  output logic              game_reset
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + 1 + 8;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t               state_q, state_d;
  logic                 wr_prev_q, wr_prev_d;
  logic                 downl_prev_q, downl_prev_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NPORTS-1:0]    port_req_q, port_req_d;
  logic [NPORTS-1:0]    pend_q, pend_d;
  logic [ADDR_W-1:0]    port_a_q, port_a_d;
  logic [1:0]           port_ds_q, port_ds_d;
  logic [15:0]          port_d_q, port_d_d;
  logic                 port_we_q, port_we_d;
  logic                 rom_loaded_q, rom_loaded_d;
  logic                 busy_q, busy_d;
  logic                 overflow_q, overflow_d;
  logic                 seen_dl_q, seen_dl_d;
  logic                 game_reset_q, game_reset_d;
  logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;

  logic [ENT_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [ENT_W-1:0]     wr_entry;
  logic [ENT_W-1:0]     rd_entry;
  logic [ADDR_W:0]      rd_addr;
  logic [7:0]           rd_byte;
  logic                 wr_edge, accept, full, push, pop, drop, dl_start;

  // Only ioctl_addr[ADDR_W:0] is stored; any upper bits are beyond the sdram word space.
  if (ADDR_W < 24) begin : g_unused_addr
    logic unused_addr_bits;
    assign unused_addr_bits = ^ioctl_addr[24:ADDR_W+1];
  end

  always_comb begin
    wr_edge  = ioctl_wr & ~wr_prev_q;
    dl_start = ioctl_downl & ~downl_prev_q;
    accept   = wr_edge & ioctl_downl & (ioctl_index == ROM_INDEX);
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    pop      = (state_q == ST_IDLE) && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push     = accept & (~full | pop);
    drop     = accept & full & ~pop;
    wr_entry = {ioctl_addr[ADDR_W:0], ioctl_dout};
    rd_entry = fifo_mem[rd_ptr_q];
    rd_addr  = rd_entry[ENT_W-1:8];
    rd_byte  = rd_entry[7:0];
  end

  always_comb begin
    wr_prev_d    = ioctl_wr;
    downl_prev_d = ioctl_downl;
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    state_d    = state_q;
    port_req_d = port_req_q;
    pend_d     = pend_q;
    port_a_d   = port_a_q;
    port_ds_d  = port_ds_q;
    port_d_d   = port_d_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          port_a_d  = rd_addr[ADDR_W:1];
          port_ds_d = {rd_addr[0], ~rd_addr[0]};
          port_d_d  = {rd_byte, rd_byte};
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        port_req_d = port_req_q ^ port_en;
        pend_d     = port_en;
        state_d    = (port_en == '0) ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        // A port is done once its ack has caught up with its request toggle.
        pend_d = pend_q & (port_ack ^ port_req_q);
        if (pend_d == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    overflow_d = dl_start ? 1'b0 : overflow_q;
    if (drop) overflow_d = 1'b1;
    seen_dl_d    = seen_dl_q | ioctl_downl;
    rom_loaded_d = rom_loaded_q |
                   (~ioctl_downl & seen_dl_q & (state_q == ST_IDLE) & (count_q == '0));
    busy_d       = (count_d != '0) | (state_d != ST_IDLE);
    port_we_d    = ioctl_downl | busy_d;

    if (reset_req | ~rom_loaded_q | ioctl_downl) rst_cnt_d = '1;
    else if (rst_cnt_q != '0)                    rst_cnt_d = rst_cnt_q - RST_CNT_W'(1);
    else                                         rst_cnt_d = rst_cnt_q;
    game_reset_d = (rst_cnt_q != '0);
  end

  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wr_prev_q    <= 1'b0;
      downl_prev_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      port_req_q   <= '0;
      pend_q       <= '0;
      port_a_q     <= '0;
      port_ds_q    <= '0;
      port_d_q     <= '0;
      port_we_q    <= 1'b0;
      rom_loaded_q <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      seen_dl_q    <= 1'b0;
      game_reset_q <= 1'b1;
      rst_cnt_q    <= '1;
    end else begin
      state_q      <= state_d;
      wr_prev_q    <= wr_prev_d;
      downl_prev_q <= downl_prev_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      port_req_q   <= port_req_d;
      pend_q       <= pend_d;
      port_a_q     <= port_a_d;
      port_ds_q    <= port_ds_d;
      port_d_q     <= port_d_d;
      port_we_q    <= port_we_d;
      rom_loaded_q <= rom_loaded_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      seen_dl_q    <= seen_dl_d;
      game_reset_q <= game_reset_d;
      rst_cnt_q    <= rst_cnt_d;
    end
  end

  assign port_req   = port_req_q;
  assign port_a     = port_a_q;
  assign port_ds    = port_ds_q;
  assign port_d     = port_d_q;
  assign port_we    = port_we_q;
  assign rom_loaded = rom_loaded_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign game_reset = game_reset_q;

`ifdef ROM_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = dl_start ? 16'h0000 : checksum_q;
    if (push) checksum_d = checksum_d + {8'h00, ioctl_dout};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) checksum_q <= 16'h0000;
    else          checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Bench for rom_download_ctrl: directed download phases plus randomized bytes, checked against a
// queue-based model of what each sdram port must receive. Follows ROM_CHECKSUM_EN if defined.
`timescale 1ns/1ps
module tb_rom_download_ctrl;
  localparam int NPORTS = 2;
  localparam int ADDR_W = 23;
  localparam int FIFO_DEPTH = 4;
  localparam int RST_CNT_W = 4;
  localparam logic [7:0] ROM_IDX = 8'd0;
  localparam int EW = ADDR_W + 18;

  typedef logic [EW-1:0] wr_t;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic              reset_n = 1'b0;
  logic              ioctl_downl = 1'b0;
  logic [7:0]        ioctl_index = 8'd0;
  logic              ioctl_wr = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_dout = '0;
  logic [NPORTS-1:0] port_en = '1;
  logic [NPORTS-1:0] port_req;
  logic [NPORTS-1:0] port_ack;
  logic [ADDR_W-1:0] port_a;
  logic [1:0]        port_ds;
  logic [15:0]       port_d;
  logic              port_we;
  logic              reset_req = 1'b0;
  logic              rom_loaded, busy, overflow, game_reset;
`ifdef ROM_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  rom_download_ctrl #(
    .NPORTS(NPORTS), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH),
    .ROM_INDEX(ROM_IDX), .RST_CNT_W(RST_CNT_W)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_downl(ioctl_downl),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .port_en(port_en), .port_req(port_req),
    .port_ack(port_ack), .port_a(port_a), .port_ds(port_ds), .port_d(port_d),
    .port_we(port_we), .reset_req(reset_req), .rom_loaded(rom_loaded),
    .busy(busy), .overflow(overflow), .game_reset(game_reset)
`ifdef ROM_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  int checks = 0;
  int errors = 0;
  wr_t exp0[$];
  wr_t exp1[$];
  int tog_cnt[NPORTS] = '{default: 0};
  logic [NPORTS-1:0] withhold = '0;
  int lat_fixed = 2;
  int stall_fill = -1;
  logic exp_ovf = 1'b0;
  logic [15:0] cs_model = 16'h0000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // What an sdram port must see for a byte: word address, lane select, byte on both lanes.
  function automatic wr_t mk(input logic [24:0] addr, input logic [7:0] b);
    return {addr[ADDR_W:1], addr[0], ~addr[0], b, b};
  endfunction

  task automatic got_write(input int i, input wr_t w);
    if (i == 0) begin
      check("p0_write_expected", exp0.size() != 0, 1'b1);
      if (exp0.size() != 0) check("p0_write", w, exp0.pop_front());
    end else begin
      check("p1_write_expected", exp1.size() != 0, 1'b1);
      if (exp1.size() != 0) check("p1_write", w, exp1.pop_front());
    end
  endtask

  // sdram side: logs each request toggle and echoes ack after a latency.
  initial begin
    logic [NPORTS-1:0] seen;
    int cnt[NPORTS];
    seen = '0;
    port_ack = '0;
    for (int i = 0; i < NPORTS; i++) cnt[i] = 0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        seen = '0;
        port_ack = '0;
        continue;
      end
      for (int i = 0; i < NPORTS; i++) begin
        if (port_req[i] != seen[i]) begin
          seen[i] = port_req[i];
          tog_cnt[i]++;
          cnt[i] = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
          $display("write port%0d a=0x%0h ds=%b d=0x%04h", i, port_a, port_ds, port_d);
          got_write(i, {port_a, port_ds, port_d});
        end else if (port_ack[i] != port_req[i] && !withhold[i]) begin
          if (cnt[i] <= 1) port_ack[i] = port_req[i];
          else cnt[i]--;
        end
      end
    end
  end

  task automatic send(input logic [24:0] addr, input logic [7:0] b, input logic [7:0] idx,
                      input int gap);
    bit acc;
    @(negedge clk_sys);
    ioctl_addr = addr;
    ioctl_dout = b;
    ioctl_index = idx;
    ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    acc = ioctl_downl && (idx == ROM_IDX);
    if (acc && stall_fill >= 0) begin
      if (stall_fill < FIFO_DEPTH) stall_fill++;
      else begin
        acc = 1'b0;
        exp_ovf = 1'b1;
      end
    end
    if (acc) begin
      if (port_en[0]) exp0.push_back(mk(addr, b));
      if (port_en[1]) exp1.push_back(mk(addr, b));
      cs_model = cs_model + {8'h00, b};
    end
    $display("byte idx=%0d addr=0x%0h data=0x%02h accepted=%0d", idx, addr, b, acc);
    repeat (gap) @(negedge clk_sys);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk_sys);
    while ((busy || port_ack != port_req) && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    check(tag, {busy, port_ack ^ port_req}, '0);
  endtask

  task automatic start_download();
    @(negedge clk_sys);
    ioctl_downl = 1'b1;
    cs_model = 16'h0000;
    exp_ovf = 1'b0;
    @(negedge clk_sys);
    check("dl_start_ovf_clear", overflow, exp_ovf);
  endtask

  task automatic count_reset_stretch(input string tag);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_sys);
      if (k == 1 || k == 15) check({tag, "_held"}, game_reset, 1'b1);
      if (k == 16) check({tag, "_released"}, game_reset, 1'b0);
    end
  endtask

  initial begin
    int n;
    logic [NPORTS-1:0] req_snap;
    int t0, t1;

    repeat (3) @(negedge clk_sys);
    check("rst_game_reset", game_reset, 1'b1);
    check("rst_port_req", port_req, '0);
    check("rst_rom_loaded", rom_loaded, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_port_bus", {port_we, port_a, port_ds, port_d}, '0);
    reset_n = 1'b1;

    // Download 1: two directed bytes, then randomized traffic.
    start_download();
    check("dl1_game_reset", game_reset, 1'b1);
    lat_fixed = 2;
    send(25'h000, 8'h11, 8'd0, 3);
    send(25'h001, 8'h22, 8'd0, 3);
    wait_idle("pair_idle");
    check("pair_toggles0", tog_cnt[0], 2);
    check("pair_toggles1", tog_cnt[1], 2);
    check("dl_port_we", port_we, 1'b1);

    lat_fixed = 0;
    for (int i = 0; i < 30; i++) begin
      send(25'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0) ? 8'd1 : 8'd0,
           int'($urandom_range(4, 8)));
    end
    wait_idle("rand_idle");
    check("rand_no_overflow", overflow, exp_ovf);
    check("rand_all_written", exp0.size() + exp1.size(), 0);

    // End of download with three bytes still queued.
    send(25'h100, 8'hA1, 8'd0, 0);
    send(25'h101, 8'hB2, 8'd0, 0);
    send(25'h102, 8'hC3, 8'd0, 0);
    ioctl_downl = 1'b0;
    check("end_not_loaded", rom_loaded, 1'b0);
    check("end_busy", busy, 1'b1);
    n = 0;
    while (!rom_loaded && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check("loaded_after_drain", rom_loaded, 1'b1);
    check("drained_at_loaded", {busy, port_ack ^ port_req}, '0);
    check("queued_written", exp0.size() + exp1.size(), 0);
    check("idle_port_we", port_we, 1'b0);
    count_reset_stretch("stretch");

    // User reset re-arms the full stretch.
    @(negedge clk_sys);
    reset_req = 1'b1;
    @(negedge clk_sys);
    reset_req = 1'b0;
    count_reset_stretch("user_reset");

    // Download 2: foreign index, port masks, stall with overflow.
    start_download();
    @(negedge clk_sys);
    check("dl2_game_reset", game_reset, 1'b1);
    check("dl2_rom_loaded_kept", rom_loaded, 1'b1);
    t0 = tog_cnt[0];
    t1 = tog_cnt[1];
    for (int i = 0; i < 3; i++) begin
      send(25'(i), 8'h40 + 8'(i), 8'd1, 0);
      check("idx1_busy", busy, 1'b0);
    end
    repeat (4) @(negedge clk_sys);
    check("idx1_no_toggle", {tog_cnt[0] - t0, tog_cnt[1] - t1}, '0);

    port_en = 2'b01;
    send(25'h200, 8'h5C, 8'd0, 2);
    send(25'h203, 8'h6D, 8'd0, 2);
    wait_idle("en01_idle");
    check("en01_p0", tog_cnt[0] - t0, 2);
    check("en01_p1", tog_cnt[1] - t1, 0);
    port_en = 2'b00;
    req_snap = port_req;
    send(25'h204, 8'h7E, 8'd0, 2);
    wait_idle("en00_idle");
    check("en00_no_toggle", port_req, req_snap);
    port_en = 2'b11;

    withhold = 2'b10;
    lat_fixed = 1;
    t0 = tog_cnt[0];
    send(25'h300, 8'h01, 8'd0, 4);
    stall_fill = 0;
    for (int i = 1; i <= 5; i++) send(25'h300 + 25'(i), 8'h01 + 8'(i), 8'd0, 1);
    check("stall_overflow", overflow, exp_ovf);
    check("stall_no_pop", tog_cnt[0] - t0, 1);
    check("stall_busy", busy, 1'b1);
    withhold = 2'b00;
    stall_fill = -1;
    wait_idle("stall_idle");
    check("stall_written", exp0.size() + exp1.size(), 0);

    ioctl_downl = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("dl2_ovf_sticky", overflow, 1'b1);
    check("dl2_loaded", rom_loaded, 1'b1);
    check("dl2_port_we", port_we, 1'b0);

    // Download 3: checksum bytes, then reset in the middle of a write.
    start_download();
`ifdef ROM_CHECKSUM_EN
    check("cs_cleared", checksum, 16'h0000);
`endif
    send(25'h000, 8'hFF, 8'd0, 1);
    send(25'h001, 8'hFF, 8'd0, 1);
    send(25'h002, 8'h02, 8'd0, 1);
    wait_idle("cs_idle");
`ifdef ROM_CHECKSUM_EN
    check("cs_sum", checksum, cs_model);
`endif
    withhold = 2'b11;
    send(25'h010, 8'h5A, 8'd0, 4);
    check("mid_busy", busy, 1'b1);
    reset_n = 1'b0;
    @(negedge clk_sys);
    check("abort_port_req", port_req, '0);
    check("abort_state", {busy, rom_loaded, overflow}, '0);
    check("abort_game_reset", game_reset, 1'b1);
    check("final_queues", exp0.size() + exp1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
